// File: rtl/reservation_station_scheduler.sv
// Reservation station for one Tomasulo FU: buffers issued ops, snoops the CDB for operands,
// and dispatches the oldest ready entry one cycle after it becomes ready, with a 2-cycle minimum gap.
module reservation_station_scheduler #(
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 3,
  parameter int DATA_W  = 16
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [3:0]                     issue_op,
  input  logic [TAG_W-1:0]               issue_tag,
  input  logic [DATA_W-1:0]              issue_vj,
  input  logic [DATA_W-1:0]              issue_vk,
  input  logic                           issue_qj_valid,
  input  logic                           issue_qk_valid,
  input  logic [TAG_W-1:0]               issue_qj,
  input  logic [TAG_W-1:0]               issue_qk,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  input  logic                           fu_available,
  output logic                           fu_start,
  output logic [3:0]                     fu_op,
  output logic [TAG_W-1:0]               fu_tag,
  output logic [DATA_W-1:0]              fu_r2,
  output logic [DATA_W-1:0]              fu_r1,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int AGE_W = $clog2(ENTRIES);
  localparam int OCC_W = $clog2(ENTRIES+1);

  logic              busy_q [ENTRIES], busy_d [ENTRIES];
  logic [3:0]        op_q   [ENTRIES], op_d   [ENTRIES];
  logic [TAG_W-1:0]  tag_q  [ENTRIES], tag_d  [ENTRIES];
  logic [DATA_W-1:0] vj_q   [ENTRIES], vj_d   [ENTRIES];
  logic [DATA_W-1:0] vk_q   [ENTRIES], vk_d   [ENTRIES];
  logic              qjv_q  [ENTRIES], qjv_d  [ENTRIES];
  logic              qkv_q  [ENTRIES], qkv_d  [ENTRIES];
  logic [TAG_W-1:0]  qj_q   [ENTRIES], qj_d   [ENTRIES];
  logic [TAG_W-1:0]  qk_q   [ENTRIES], qk_d   [ENTRIES];
  logic [AGE_W-1:0]  age_q  [ENTRIES], age_d  [ENTRIES];

  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              fu_start_q;
  logic [3:0]        fu_op_q;
  logic [TAG_W-1:0]  fu_tag_q;
  logic [DATA_W-1:0] fu_r2_q, fu_r1_q;

  logic              sel_found, alloc_found, alloc, dispatch;
  logic [IDX_W-1:0]  sel_idx, alloc_idx;
  logic [AGE_W-1:0]  sel_age;
  logic              byp_j, byp_k;

  assign issue_ready = (occ_q != OCC_W'(ENTRIES));
  assign alloc       = issue_valid && issue_ready;
  // fu_start_q doubles as start_pending: fu_available lags the pulse by a cycle.
  assign dispatch    = sel_found && fu_available && !fu_start_q;
  assign byp_j       = issue_qj_valid && cdb_valid && (issue_qj == cdb_tag);
  assign byp_k       = issue_qk_valid && cdb_valid && (issue_qk == cdb_tag);

  always_comb begin
    sel_found   = 1'b0;
    sel_idx     = '0;
    sel_age     = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && !qjv_q[i] && !qkv_q[i] && (!sel_found || age_q[i] > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age_q[i];
      end
      if (!busy_q[i] && !alloc_found) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      busy_d[i] = busy_q[i];
      op_d[i]   = op_q[i];
      tag_d[i]  = tag_q[i];
      vj_d[i]   = vj_q[i];
      vk_d[i]   = vk_q[i];
      qjv_d[i]  = qjv_q[i];
      qkv_d[i]  = qkv_q[i];
      qj_d[i]   = qj_q[i];
      qk_d[i]   = qk_q[i];
      age_d[i]  = age_q[i];
      if (busy_q[i]) begin
        if (qjv_q[i] && cdb_valid && (qj_q[i] == cdb_tag)) begin
          vj_d[i]  = cdb_data;
          qjv_d[i] = 1'b0;
        end
        if (qkv_q[i] && cdb_valid && (qk_q[i] == cdb_tag)) begin
          vk_d[i]  = cdb_data;
          qkv_d[i] = 1'b0;
        end
        // Ages count younger entries: new arrivals push up, departures of younger ones pull down.
        age_d[i] = age_q[i] + AGE_W'(alloc) - AGE_W'(dispatch && (age_q[i] > sel_age));
      end
      if (dispatch && (sel_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b0;
        age_d[i]  = '0;
      end
      if (alloc && alloc_found && (alloc_idx == IDX_W'(i))) begin
        busy_d[i] = 1'b1;
        op_d[i]   = issue_op;
        tag_d[i]  = issue_tag;
        vj_d[i]   = byp_j ? cdb_data : issue_vj;
        vk_d[i]   = byp_k ? cdb_data : issue_vk;
        qjv_d[i]  = issue_qj_valid && !byp_j;
        qkv_d[i]  = issue_qk_valid && !byp_k;
        qj_d[i]   = issue_qj;
        qk_d[i]   = issue_qk;
        age_d[i]  = '0;
      end
    end
    occ_d = occ_q + OCC_W'(alloc) - OCC_W'(dispatch);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_q[i] <= 1'b0;
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        qjv_q[i]  <= 1'b0;
        qkv_q[i]  <= 1'b0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        age_q[i]  <= '0;
      end
      occ_q      <= '0;
      fu_start_q <= 1'b0;
      fu_op_q    <= '0;
      fu_tag_q   <= '0;
      fu_r2_q    <= '0;
      fu_r1_q    <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        busy_q[i] <= busy_d[i];
        op_q[i]   <= op_d[i];
        tag_q[i]  <= tag_d[i];
        vj_q[i]   <= vj_d[i];
        vk_q[i]   <= vk_d[i];
        qjv_q[i]  <= qjv_d[i];
        qkv_q[i]  <= qkv_d[i];
        qj_q[i]   <= qj_d[i];
        qk_q[i]   <= qk_d[i];
        age_q[i]  <= age_d[i];
      end
      occ_q      <= occ_d;
      fu_start_q <= dispatch;
      if (dispatch) begin
        fu_op_q  <= op_q[sel_idx];
        fu_tag_q <= tag_q[sel_idx];
        fu_r2_q  <= vj_q[sel_idx];
        fu_r1_q  <= vk_q[sel_idx];
      end
    end
  end

  assign fu_start  = fu_start_q;
  assign fu_op     = fu_op_q;
  assign fu_tag    = fu_tag_q;
  assign fu_r2     = fu_r2_q;
  assign fu_r1     = fu_r1_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_reservation_station_scheduler.sv
// Bench for reservation_station_scheduler: directed scenarios then random traffic,
// scored against an in-order queue model of the station.
module tb_reservation_station_scheduler;

  localparam int ENTRIES = 4;
  localparam int TAG_W   = 3;
  localparam int DATA_W  = 16;

  logic              clock, reset_n;
  logic              issue_valid, issue_ready;
  logic [3:0]        issue_op;
  logic [TAG_W-1:0]  issue_tag, issue_qj, issue_qk;
  logic [DATA_W-1:0] issue_vj, issue_vk;
  logic              issue_qj_valid, issue_qk_valid;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              fu_available, fu_start;
  logic [3:0]        fu_op;
  logic [TAG_W-1:0]  fu_tag;
  logic [DATA_W-1:0] fu_r2, fu_r1;
  logic [2:0]        occupancy;

  reservation_station_scheduler #(.ENTRIES(ENTRIES), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_tag(issue_tag), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_valid(issue_qj_valid), .issue_qk_valid(issue_qk_valid),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .fu_available(fu_available), .fu_start(fu_start), .fu_op(fu_op), .fu_tag(fu_tag),
    .fu_r2(fu_r2), .fu_r1(fu_r1), .occupancy(occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: entries kept in allocation order, so the oldest ready one is simply the first ready one.
  typedef struct {
    logic [3:0]        op;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] vj, vk;
    logic              qjv, qkv;
    logic [TAG_W-1:0]  qj, qk;
  } ent_t;

  ent_t        rs[$];
  logic [38:0] exp_q[$];
  bit          pend      = 1'b0;
  bit          exp_start = 1'b0;

  always @(posedge clock) begin
    int   hit;
    bit   room;
    ent_t n;
    if (!reset_n) begin
      rs.delete();
      exp_q.delete();
      pend      = 1'b0;
      exp_start = 1'b0;
    end else begin
      room = (rs.size() < ENTRIES);
      hit  = -1;
      if (fu_available && !pend) begin
        for (int i = 0; i < rs.size(); i++)
          if (hit < 0 && !rs[i].qjv && !rs[i].qkv) hit = i;
      end
      if (hit >= 0) begin
        exp_q.push_back({rs[hit].op, rs[hit].tag, rs[hit].vj, rs[hit].vk});
        rs.delete(hit);
      end
      pend      = (hit >= 0);
      exp_start = (hit >= 0);
      for (int i = 0; i < rs.size(); i++) begin
        if (cdb_valid && rs[i].qjv && rs[i].qj == cdb_tag) begin rs[i].vj = cdb_data; rs[i].qjv = 1'b0; end
        if (cdb_valid && rs[i].qkv && rs[i].qk == cdb_tag) begin rs[i].vk = cdb_data; rs[i].qkv = 1'b0; end
      end
      if (issue_valid && room) begin
        n.op  = issue_op;
        n.tag = issue_tag;
        n.qj  = issue_qj;
        n.qk  = issue_qk;
        n.qjv = issue_qj_valid && !(cdb_valid && issue_qj == cdb_tag);
        n.qkv = issue_qk_valid && !(cdb_valid && issue_qk == cdb_tag);
        n.vj  = (issue_qj_valid && !n.qjv) ? cdb_data : issue_vj;
        n.vk  = (issue_qk_valid && !n.qkv) ? cdb_data : issue_vk;
        rs.push_back(n);
      end
    end
  end

  always @(negedge clock) begin
    logic [38:0] e;
    chk("fu_start", fu_start, exp_start);
    if (exp_start || fu_start) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dispatch_unexpected actual=fu_start required=no_dispatch at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (fu_start) chk("dispatch_fields", {fu_op, fu_tag, fu_r2, fu_r1}, e);
      end
    end
    chk("occupancy", occupancy, rs.size());
    chk("issue_ready", issue_ready, rs.size() != ENTRIES);
  end

  task automatic issue(input logic [3:0] op, input logic [TAG_W-1:0] tag,
                       input logic [DATA_W-1:0] vj, input logic [DATA_W-1:0] vk,
                       input logic qjv, input logic [TAG_W-1:0] qj,
                       input logic qkv, input logic [TAG_W-1:0] qk);
    issue_valid = 1'b1; issue_op = op; issue_tag = tag; issue_vj = vj; issue_vk = vk;
    issue_qj_valid = qjv; issue_qj = qj; issue_qk_valid = qkv; issue_qk = qk;
    @(negedge clock);
    issue_valid = 1'b0;
  endtask

  task automatic bcast(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    @(negedge clock);
    cdb_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic reset_checks(input string tagname);
    chk({tagname, "_occupancy"}, occupancy, 0);
    chk({tagname, "_issue_ready"}, issue_ready, 1);
    chk({tagname, "_fu_start"}, fu_start, 0);
    chk({tagname, "_fu_outputs"}, {fu_op, fu_tag, fu_r2, fu_r1}, 0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1 reset_checks("async_reset");
    @(negedge clock);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    reset_n = 1'b0;
    issue_valid = 1'b0; issue_op = '0; issue_tag = '0; issue_vj = '0; issue_vk = '0;
    issue_qj_valid = 1'b0; issue_qk_valid = 1'b0; issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; fu_available = 1'b1;
    #3 reset_checks("reset");
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);

    // Single ready add.
    issue(4'b0000, 3'd1, 16'd5, 16'd3, 1'b0, 3'd0, 1'b0, 3'd0);
    idle(4);

    // Sub waiting on tag 2, broadcast three cycles later.
    issue(4'b0001, 3'd4, 16'd0, 16'd4, 1'b1, 3'd2, 1'b0, 3'd0);
    idle(2);
    bcast(3'd2, 16'd10);
    idle(4);

    // Fill the station while the FU is busy, try a fifth, then drain in order.
    fu_available = 1'b0;
    for (int i = 0; i < 5; i++)
      issue(4'(i % 2), 3'(i), 16'(100 + i), 16'(200 + i), 1'b0, 3'd0, 1'b0, 3'd0);
    idle(2);
    fu_available = 1'b1;
    idle(10);

    // Older entry waits on tag 3, younger one is ready.
    issue(4'b0100, 3'd5, 16'd7, 16'd8, 1'b1, 3'd3, 1'b0, 3'd0);
    issue(4'b0101, 3'd6, 16'd9, 16'd2, 1'b0, 3'd0, 1'b0, 3'd0);
    bcast(3'd3, 16'h1234);
    idle(6);

    // Issue-time bypass from the CDB.
    cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 16'h00FF;
    issue(4'b0000, 3'd7, 16'hDEAD, 16'd1, 1'b1, 3'd6, 1'b0, 3'd0);
    cdb_valid = 1'b0;
    idle(4);

    // FU stalled with two ready entries, then reset in the middle of the wait.
    fu_available = 1'b0;
    issue(4'b0001, 3'd1, 16'd50, 16'd20, 1'b0, 3'd0, 1'b0, 3'd0);
    issue(4'b0100, 3'd2, 16'd6, 16'd7, 1'b0, 3'd0, 1'b0, 3'd0);
    idle(3);
    pulse_reset();
    fu_available = 1'b1;
    idle(3);

    // Random traffic.
    for (int c = 0; c < 2000; c++) begin
      issue_valid    = ($urandom % 2) == 0;
      issue_op       = 4'($urandom_range(0, 3) & 1) | (($urandom % 2) != 0 ? 4'b0100 : 4'b0000);
      issue_tag      = 3'($urandom);
      issue_vj       = 16'($urandom);
      issue_vk       = 16'($urandom);
      issue_qj_valid = ($urandom % 3) == 0;
      issue_qk_valid = ($urandom % 3) == 0;
      issue_qj       = 3'($urandom);
      issue_qk       = 3'($urandom);
      cdb_valid      = ($urandom % 2) == 0;
      cdb_tag        = 3'($urandom);
      cdb_data       = 16'($urandom);
      fu_available   = ($urandom % 4) != 0;
      if (c == 1000) pulse_reset();
      @(negedge clock);
    end
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
